pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 253 +++++++++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a classic 5-stage MIPS pipeline.
// Decides stalls, flushes and ALU/jr operand forwarding from the IF/ID,
// ID/EX, EX/MEM and MEM/WB register fields. Control and forward outputs are
// combinational (zero-cycle); only the FSM state and event counters are held
// in flops. Stall/flush events are tallied in saturating counters.
module pipeline_hazard_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,

  // IF/ID instruction
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 id_jump,
  input  logic                 id_jr,

  // ID/EX instruction
  input  logic [4:0]           ex_rs,
  input  logic [4:0]           ex_rt,
  input  logic                 ex_memread,
  input  logic                 ex_regwrite,
  input  logic [4:0]           ex_writereg,

  // EX/MEM instruction
  input  logic                 mem_regwrite,
  input  logic                 mem_memread,
  input  logic [4:0]           mem_writereg,

  // MEM/WB instruction
  input  logic                 wb_regwrite,
  input  logic [4:0]           wb_writereg,

  // Branch resolved in EX
  input  logic                 ex_branch_taken,

  // Pipeline control
  output logic                 pc_enable,
  output logic                 if_id_enable,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,

  // Forwarding selects
  output logic [1:0]           forward_a,
  output logic [1:0]           forward_b,
  output logic                 forward_jr,

  // Status
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    JR_WAIT    = 2'b10,
    UNUSED_ST  = 2'b11
  } hzState_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // A producer matches a source only if it writes, and never through $zero.
  function automatic logic regMatch(input logic       writes,
                                    input logic [4:0] dest,
                                    input logic [4:0] src);
    return writes & (dest != 5'd0) & (dest == src);
  endfunction

  // ALU operand select: the younger EX/MEM result takes precedence over MEM/WB.
  function automatic logic [1:0] fwdSelect(input logic memHit,
                                           input logic wbHit);
    logic [1:0] sel;
    if (memHit) begin
      sel = FWD_EXMEM;
    end else if (wbHit) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_IDEX;
    end
    return sel;
  endfunction

  hzState_t             stateR;
  hzState_t             nextStateS;
  logic [CNT_WIDTH-1:0] stallCntR;
  logic [CNT_WIDTH-1:0] flushCntR;

  logic loadUseS;
  logic jrDepS;
  logic stallIncS;
  logic flushIncS;

  logic pcEnS;
  logic ifIdEnS;
  logic ifIdFlushS;
  logic idExFlushS;
  logic [1:0] fwdAS;
  logic [1:0] fwdBS;
  logic fwdJrS;

  // A load in MEM needs no special treatment here: its data only becomes
  // forwardable from MEM/WB, which the pipeline handles via the load-use bubble.
  logic unusedMemRead;
  assign unusedMemRead = mem_memread;

  // Hazard detection terms from the current pipeline contents.
  always_comb begin
    loadUseS = regMatch(ex_memread, ex_writereg, id_rs) & id_uses_rs;
    loadUseS = loadUseS | (regMatch(ex_memread, ex_writereg, id_rt) & id_uses_rt);

    jrDepS = id_jr & (id_rs != 5'd0) &
             (regMatch(ex_regwrite, ex_writereg, id_rs) |
              regMatch(mem_regwrite, mem_writereg, id_rs));
  end

  // Next-state and stall/flush controls; branch overrides every state.
  always_comb begin
    nextStateS = stateR;
    pcEnS      = 1'b1;
    ifIdEnS    = 1'b1;
    ifIdFlushS = 1'b0;
    idExFlushS = 1'b0;
    stallIncS  = 1'b0;
    flushIncS  = 1'b0;

    if (reset) begin
      nextStateS = RUN;
    end else if (ex_branch_taken) begin
      // Squash both younger instructions; a concurrent stall is abandoned.
      ifIdFlushS = 1'b1;
      idExFlushS = 1'b1;
      flushIncS  = 1'b1;
      nextStateS = RUN;
    end else begin
      case (stateR)
        RUN: begin
          if (loadUseS) begin
            pcEnS      = 1'b0;
            ifIdEnS    = 1'b0;
            idExFlushS = 1'b1;
            stallIncS  = 1'b1;
            nextStateS = LOAD_STALL;
          end else if (jrDepS) begin
            pcEnS      = 1'b0;
            ifIdEnS    = 1'b0;
            idExFlushS = 1'b1;
            stallIncS  = 1'b1;
            nextStateS = JR_WAIT;
          end else if (id_jump | id_jr) begin
            // Target known in ID: drop the sequentially fetched instruction.
            ifIdFlushS = 1'b1;
            flushIncS  = 1'b1;
            nextStateS = RUN;
          end else begin
            nextStateS = RUN;
          end
        end

        LOAD_STALL: begin
          // Exactly one bubble; the load has now reached MEM.
          nextStateS = RUN;
        end

        JR_WAIT: begin
          if (jrDepS) begin
            pcEnS      = 1'b0;
            ifIdEnS    = 1'b0;
            idExFlushS = 1'b1;
            stallIncS  = 1'b1;
            nextStateS = JR_WAIT;
          end else begin
            ifIdFlushS = 1'b1;
            flushIncS  = 1'b1;
            nextStateS = RUN;
          end
        end

        default: begin
          nextStateS = RUN;
        end
      endcase
    end
  end

  // Operand forwarding selects for the EX ALU and the ID-stage jr target.
  always_comb begin
    fwdAS  = FWD_IDEX;
    fwdBS  = FWD_IDEX;
    fwdJrS = 1'b0;
    if (reset) begin
      fwdAS  = FWD_IDEX;
      fwdBS  = FWD_IDEX;
      fwdJrS = 1'b0;
    end else begin
      fwdAS  = fwdSelect(regMatch(mem_regwrite, mem_writereg, ex_rs),
                         regMatch(wb_regwrite, wb_writereg, ex_rs));
      fwdBS  = fwdSelect(regMatch(mem_regwrite, mem_writereg, ex_rt),
                         regMatch(wb_regwrite, wb_writereg, ex_rt));
      fwdJrS = id_jr & regMatch(wb_regwrite, wb_writereg, id_rs);
    end
  end

  // State register; reset abandons any stall in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR <= RUN;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCntR <= {CNT_WIDTH{1'b0}};
    end else if (stallIncS && (stallCntR != CNT_MAX)) begin
      stallCntR <= stallCntR + CNT_ONE;
    end else begin
      stallCntR <= stallCntR;
    end
  end

  // Saturating flush counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      flushCntR <= {CNT_WIDTH{1'b0}};
    end else if (flushIncS && (flushCntR != CNT_MAX)) begin
      flushCntR <= flushCntR + CNT_ONE;
    end else begin
      flushCntR <= flushCntR;
    end
  end

  assign pc_enable    = pcEnS;
  assign if_id_enable = ifIdEnS;
  assign if_id_flush  = ifIdFlushS;
  assign id_ex_flush  = idExFlushS;
  assign forward_a    = fwdAS;
  assign forward_b    = fwdBS;
  assign forward_jr   = fwdJrS;
  assign state        = stateR;
  assign stall_count  = stallCntR;
  assign flush_count  = flushCntR;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller (CNT_WIDTH=4).
// Control word = {pc_enable, if_id_enable, if_id_flush, id_ex_flush,
//                 forward_a, forward_b, forward_jr}
// Status word  = {state, stall_count, flush_count}
module tb_pipeline_hazard_controller;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs, id_rt;
  logic          id_uses_rs, id_uses_rt, id_jump, id_jr;
  logic [4:0]    ex_rs, ex_rt;
  logic          ex_memread, ex_regwrite;
  logic [4:0]    ex_writereg;
  logic          mem_regwrite, mem_memread;
  logic [4:0]    mem_writereg;
  logic          wb_regwrite;
  logic [4:0]    wb_writereg;
  logic          ex_branch_taken;
  logic          pc_enable, if_id_enable, if_id_flush, id_ex_flush;
  logic [1:0]    forward_a, forward_b;
  logic          forward_jr;
  logic [1:0]    state;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_controller #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_jr(id_jr),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_writereg(ex_writereg),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_writereg(mem_writereg),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
    .ex_branch_taken(ex_branch_taken),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .forward_a(forward_a), .forward_b(forward_b), .forward_jr(forward_jr),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string      tagQ[$];
  bit         kindQ[$];
  logic [9:0] valQ[$];
  int         nChecks = 0;
  int         nFails  = 0;

  task automatic clearIn();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_jump = 1'b0; id_jr = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_memread = 1'b0; ex_regwrite = 1'b0; ex_writereg = 5'd0;
    mem_regwrite = 1'b0; mem_memread = 1'b0; mem_writereg = 5'd0;
    wb_regwrite = 1'b0; wb_writereg = 5'd0;
    ex_branch_taken = 1'b0;
  endtask

  // Pop every pending expectation and compare it with the live outputs.
  task automatic drain();
    string      t;
    bit         k;
    logic [9:0] e;
    logic [9:0] obs;
    while (tagQ.size() > 0) begin
      t = tagQ.pop_front();
      k = kindQ.pop_front();
      e = valQ.pop_front();
      if (k) obs = {state, stall_count, flush_count};
      else   obs = {1'b0, pc_enable, if_id_enable, if_id_flush, id_ex_flush,
                    forward_a, forward_b, forward_jr};
      nChecks++;
      assert (obs === e) else begin
        nFails++;
        $error("FAIL %s observed=%b expected=%b", t, obs, e);
      end
    end
  endtask

  // Expect a combinational control word after inputs settle.
  task automatic ctl(input string tag, input logic [8:0] v);
    #1;
    tagQ.push_back(tag); kindQ.push_back(1'b0); valQ.push_back({1'b0, v});
    drain();
  endtask

  // Clock one edge, then expect the registered status.
  task automatic tick(input string tag, input logic [1:0] st, input int sc, input int fc);
    logic [CW-1:0] s4;
    logic [CW-1:0] f4;
    s4 = CW'(sc);
    f4 = CW'(fc);
    @(posedge clk);
    #1;
    tagQ.push_back(tag); kindQ.push_back(1'b1); valQ.push_back({st, s4, f4});
    drain();
  endtask

  initial begin
    // Reset with hazard-provoking inputs present: outputs must be idle.
    clearIn();
    reset = 1'b1;
    ex_branch_taken = 1'b1; ex_rs = 5'd9; mem_regwrite = 1'b1; mem_writereg = 5'd9;
    id_jr = 1'b1; id_rs = 5'd9; wb_regwrite = 1'b1; wb_writereg = 5'd9;
    ctl("reset_ctl", 9'b1_1_0_0_00_00_0);
    tick("reset_regs", 2'b00, 0, 0);
    reset = 1'b0;

    // lw $t0 in EX, add reads $t0 in ID.
    clearIn();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    ctl("lu_stall", 9'b0_0_0_1_00_00_0);
    tick("lu_state", 2'b01, 1, 0);
    clearIn();
    mem_regwrite = 1'b1; mem_memread = 1'b1; mem_writereg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    ctl("lu_release", 9'b1_1_0_0_00_00_0);
    tick("lu_back", 2'b00, 1, 0);
    clearIn();
    ex_rs = 5'd8; wb_regwrite = 1'b1; wb_writereg = 5'd8;
    ctl("lu_fwd_wb", 9'b1_1_0_0_01_00_0);
    tick("lu_done", 2'b00, 1, 0);

    // Forwarding priority and $zero exclusion.
    clearIn();
    ex_rs = 5'd9; ex_rt = 5'd9; mem_regwrite = 1'b1; mem_writereg = 5'd9;
    wb_regwrite = 1'b1; wb_writereg = 5'd9;
    ctl("fwd_mem_wins", 9'b1_1_0_0_10_10_0);
    mem_regwrite = 1'b0;
    ctl("fwd_wb", 9'b1_1_0_0_01_01_0);
    ex_rs = 5'd0;
    ctl("fwd_rs0", 9'b1_1_0_0_00_01_0);
    ex_rt = 5'd0; mem_regwrite = 1'b1; mem_writereg = 5'd0; wb_writereg = 5'd0;
    ctl("fwd_r0_dest", 9'b1_1_0_0_00_00_0);
    ex_rs = 5'd9; ex_rt = 5'd5; mem_writereg = 5'd9; wb_writereg = 5'd5;
    ctl("fwd_split", 9'b1_1_0_0_10_01_0);
    tick("fwd_no_count", 2'b00, 1, 0);

    clearIn();
    reset = 1'b1;
    ctl("reset2_ctl", 9'b1_1_0_0_00_00_0);
    tick("reset2_regs", 2'b00, 0, 0);
    reset = 1'b0;

    // jr $ra waiting on producers in EX then MEM.
    clearIn();
    id_jr = 1'b1; id_rs = 5'd31; id_uses_rs = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd31;
    ctl("jr_stall_ex", 9'b0_0_0_1_00_00_0);
    tick("jr_wait1", 2'b10, 1, 0);
    ex_regwrite = 1'b0; ex_writereg = 5'd0; mem_regwrite = 1'b1; mem_writereg = 5'd31;
    ctl("jr_stall_mem", 9'b0_0_0_1_00_00_0);
    tick("jr_wait2", 2'b10, 2, 0);
    mem_regwrite = 1'b0; mem_writereg = 5'd0; wb_regwrite = 1'b1; wb_writereg = 5'd31;
    ctl("jr_release", 9'b1_1_1_0_00_00_1);
    tick("jr_done", 2'b00, 2, 1);

    // Branch over load-use: only the flush counts.
    clearIn();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    ex_branch_taken = 1'b1;
    ctl("br_over_lu", 9'b1_1_1_1_00_00_0);
    tick("br_lu_cnt", 2'b00, 2, 2);

    clearIn();
    id_jump = 1'b1;
    ctl("jump", 9'b1_1_1_0_00_00_0);
    tick("jump_cnt", 2'b00, 2, 3);

    clearIn();
    id_jr = 1'b1; id_rs = 5'd31; id_uses_rs = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd30;
    ctl("jr_free", 9'b1_1_1_0_00_00_0);
    tick("jr_free_cnt", 2'b00, 2, 4);

    // Load-use through rt only.
    clearIn();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    id_rs = 5'd7;
    ctl("lu_rt", 9'b0_0_0_1_00_00_0);
    tick("lu_rt_state", 2'b01, 3, 4);
    clearIn();
    ctl("lu_rt_release", 9'b1_1_0_0_00_00_0);
    tick("lu_rt_back", 2'b00, 3, 4);

    // No hazard when the register is not read, or is $zero.
    clearIn();
    ex_memread = 1'b1; ex_writereg = 5'd7; id_rs = 5'd7; id_rt = 5'd7;
    ctl("lu_not_used", 9'b1_1_0_0_00_00_0);
    ex_writereg = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    ctl("lu_r0", 9'b1_1_0_0_00_00_0);
    tick("lu_none_cnt", 2'b00, 3, 4);

    // load_use outranks jr_dep.
    clearIn();
    id_jr = 1'b1; id_rs = 5'd31; id_uses_rs = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd31;
    ctl("lu_over_jr", 9'b0_0_0_1_00_00_0);
    tick("lu_over_jr_st", 2'b01, 4, 4);
    clearIn();
    ctl("lu_over_jr_rel", 9'b1_1_0_0_00_00_0);
    tick("lu_over_jr_back", 2'b00, 4, 4);

    // Flush counter saturation.
    clearIn();
    reset = 1'b1;
    tick("reset3_regs", 2'b00, 0, 0);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      clearIn();
      ex_branch_taken = 1'b1;
      ctl("sat_br_ctl", 9'b1_1_1_1_00_00_0);
      tick("flush_sat", 2'b00, 0, (i > 15) ? 15 : i);
    end

    // Reset during JR_WAIT.
    clearIn();
    id_jr = 1'b1; id_rs = 5'd31; id_uses_rs = 1'b1; ex_regwrite = 1'b1; ex_writereg = 5'd31;
    ctl("jr_pre_rst", 9'b0_0_0_1_00_00_0);
    tick("jr_pre_rst_st", 2'b10, 1, 15);
    reset = 1'b1;
    ctl("rst_in_jrwait", 9'b1_1_0_0_00_00_0);
    tick("rst_in_jrwait_regs", 2'b00, 0, 0);
    reset = 1'b0;
    ctl("post_rst_stall", 9'b0_0_0_1_00_00_0);
    tick("post_rst_st", 2'b10, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
